// File: rtl/multiword_subtractor_seq.sv
// Word-serial multiword subtractor: one WIDTH-bit word per transfer, LSW first,
// borrow chained through BR, single registered output stage with valid/ready.
module multiword_subtractor_seq #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BI,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RES,
    output logic             OUT_LAST,
    output logic             BO,
    output logic             ZERO,
    output logic             OVF
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             br_q, br_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             last_q, last_d;
    logic             bo_q, bo_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             in_xfer;
    logic             is_last;
    logic             bin;
    logic [WIDTH:0]   diff;

    assign IN_READY  = !valid_q || OUT_READY;
    assign OUT_VALID = valid_q;
    assign RES       = res_q;
    assign OUT_LAST  = last_q;
    assign BO        = bo_q;
    assign ZERO      = zero_q;
    assign OVF       = ovf_q;

    always_comb begin
        in_xfer = IN_VALID && IN_READY;
        is_last = (idx_q == LAST_IDX);
        // IDLE is exactly IDX==0, so it selects the external borrow-in
        bin     = (state_q == IDLE) ? BI : br_q;
        diff    = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, bin};

        state_d = state_q;
        idx_d   = idx_q;
        br_d    = br_q;
        res_d   = res_q;
        last_d  = last_q;
        bo_d    = bo_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        if (in_xfer) begin
            valid_d = 1'b1;
        end else if (OUT_READY) begin
            valid_d = 1'b0;
        end

        if (in_xfer) begin
            state_d = is_last ? IDLE : BUSY;
            idx_d   = is_last ? '0 : idx_q + 1'b1;
            br_d    = diff[WIDTH];
            res_d   = diff[WIDTH-1:0];
            last_d  = is_last;
            bo_d    = diff[WIDTH];
            // zero_q doubles as the running accumulator; restarts on word 0
            zero_d  = ((state_q == IDLE) ? 1'b1 : zero_q) && (diff[WIDTH-1:0] == '0);
            ovf_d   = is_last && (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            br_q    <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= '0;
            last_q  <= 1'b0;
            bo_q    <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            br_q    <= br_d;
            valid_q <= valid_d;
            res_q   <= res_d;
            last_q  <= last_d;
            bo_q    <= bo_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_multiword_subtractor_seq.sv
// Scoreboard bench: whole 32-bit operations are modelled with plain arithmetic,
// split into expected bytes, and checked by an independent output monitor.
module tb_multiword_subtractor_seq;
    localparam int W = 8;
    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A, B;
    logic         BI;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] RES;
    logic         OUT_LAST, BO, ZERO, OVF;

    typedef struct packed {
        logic [W-1:0] res;
        logic         last;
        logic         bo;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   rdy_mode = 0;
    bit   mon_en = 1'b0;

    multiword_subtractor_seq #(.WIDTH(W), .WORDS(N)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .BI(BI), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .RES(RES), .OUT_LAST(OUT_LAST), .BO(BO), .ZERO(ZERO), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: 0 = always, 1 = 1,0,0,1 pattern, 2 = random (mostly ready)
    initial begin
        int cyc = 0;
        OUT_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            case (rdy_mode)
                1:       OUT_READY = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2:       OUT_READY = ($urandom % 4) != 0;
                default: OUT_READY = 1'b1;
            endcase
        end
    end

    // Monitor: handshake rule, stall stability, and in-order scoreboard pops
    initial begin
        exp_t h, e;
        bit   stall = 1'b0;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                chk("in_ready", 64'(IN_READY), 64'(!OUT_VALID || OUT_READY));
                if (stall && OUT_VALID)
                    chk("stall_hold", 64'({RES, OUT_LAST, BO, ZERO, OVF}), 64'(h));
                if (OUT_VALID && OUT_READY) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_word: got res %0h with empty scoreboard", RES);
                    end else begin
                        e = q.pop_front();
                        chk("res", 64'(RES), 64'(e.res));
                        chk("out_last", 64'(OUT_LAST), 64'(e.last));
                        if (e.last) begin
                            chk("bo", 64'(BO), 64'(e.bo));
                            chk("zero", 64'(ZERO), 64'(e.zero));
                            chk("ovf", 64'(OVF), 64'(e.ovf));
                        end
                    end
                end
                stall = OUT_VALID && !OUT_READY;
                h     = {RES, OUT_LAST, BO, ZERO, OVF};
            end
        end
    end

    // Issue the first nw words of a 32-bit operation; gap<0 means random gaps.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                          input int gap, input int nw);
        logic [32:0] full;
        exp_t        e;
        int          t;
        int          g;
        full = {1'b0, a} - {1'b0, b} - 33'(bi);
        for (int k = 0; k < nw; k++) begin
            e.res  = full[8*k +: 8];
            e.last = (k == N - 1);
            e.bo   = full[32];
            e.zero = (full[31:0] == 32'd0);
            e.ovf  = (a[31] != b[31]) && (full[31] != a[31]);
            IN_VALID = 1'b1;
            A  = a[8*k +: 8];
            B  = b[8*k +: 8];
            BI = (k == 0) ? bi : 1'($urandom);
            t = 0;
            do begin
                @(negedge CLK);
                t++;
            end while (!IN_READY && t < 200);
            if (!IN_READY) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: stuck low for %0d cycles", t);
                IN_VALID = 1'b0;
                return;
            end
            @(posedge CLK);
            #1;
            q.push_back(e);
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (g > 0 && k < nw - 1) begin
                IN_VALID = 1'b0;
                A = W'($urandom);
                B = W'($urandom);
                repeat (g) begin
                    @(posedge CLK);
                    #1;
                end
            end
        end
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge CLK);
            t++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d words pending expected 0", q.size());
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic reset_midop(input logic [31:0] a, input logic [31:0] b);
        run_op(a, b, 1'b0, 0, 2);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        @(posedge CLK);
        #1;
        run_op(32'h00000005, 32'h00000003, 1'b0, 0, N);
        drain();
    endtask

    initial begin
        RST = 1'b1;
        IN_VALID = 1'b0;
        A = '0;
        B = '0;
        BI = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_res", 64'(RES), 64'd0);
        chk("rst_last", 64'(OUT_LAST), 64'd0);
        chk("rst_bo", 64'(BO), 64'd0);
        chk("rst_zero", 64'(ZERO), 64'd0);
        chk("rst_ovf", 64'(OVF), 64'd0);
        chk("rst_in_ready", 64'(IN_READY), 64'd1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        mon_en = 1'b1;

        run_op(32'h00000000, 32'h00000001, 1'b0, 0, N);
        run_op(32'h12345678, 32'h12345678, 1'b0, 0, N);
        run_op(32'h00000001, 32'h00000000, 1'b1, 0, N);
        run_op(32'h80000000, 32'h00000001, 1'b0, 0, N);
        drain();

        rdy_mode = 1;
        run_op($urandom, $urandom, 1'($urandom), 0, N);
        run_op($urandom, $urandom, 1'($urandom), 0, N);
        drain();
        rdy_mode = 0;

        reset_midop(32'hFFFFFFFF, 32'h00000000);
        reset_midop(32'h00000000, 32'h00000001);

        run_op(32'h00000100, 32'h00000001, 1'b0, 3, N);
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 24; i++)
            run_op($urandom, (i % 5 == 0) ? 32'h0 : 32'($urandom), 1'($urandom), -1, N);
        drain();
        rdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
